btn_event_ctrl: RTL

- Sequencer/arbiter between the debounced button filter bank and the CPU peripheral bus.
- Turns debounced button levels into discrete press events and arbitrates simultaneous presses round-robin.
- Queues events in a small FIFO and presents them to the CPU through a valid/ready pop interface, with an interrupt and a sticky lost-event flag.

---
 rtl/btn_event_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/btn_event_ctrl.sv
// Button event sequencer: edge-detects debounced buttons, arbitrates round-robin into an event FIFO.
// Optional macro BTN_RELEASE_EVT_EN adds release (falling-edge) events as extra sources.
module btn_event_ctrl #(
  parameter  int N_BTN = 4,
  parameter  int DEPTH = 4,
  localparam int ID_W  = $clog2(N_BTN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_BTN-1:0]         btn_i,
  input  logic [N_BTN-1:0]         mask_i,
  input  logic                     evt_ready_i,
  input  logic                     ovf_clr_i,
  output logic                     evt_valid_o,
  output logic [ID_W:0]            evt_id_o,
  output logic [$clog2(DEPTH):0]   evt_count_o,
  output logic                     ovf_o,
  output logic                     irq_o
);

  localparam int AW = $clog2(DEPTH);
`ifdef BTN_RELEASE_EVT_EN
  localparam int N_SRC = 2 * N_BTN;
`else
  localparam int N_SRC = N_BTN;
`endif
  localparam int SRC_W = $clog2(N_SRC);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [N_BTN-1:0] btn_q;
  logic             armed;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] pending_nxt;
  logic [N_SRC-1:0] src_edge;
  logic [N_SRC-1:0] src_en;
  logic [N_SRC-1:0] grant_oh;
  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] rr_nxt;
  logic [SRC_W-1:0] grant_idx;
  logic             grant_vld;
  logic             push_ok;
  logic             push;
  logic             pop;
  logic             lost;
  logic [ID_W:0]    entry;
  logic [ID_W:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  assign evt_valid_o = (count != '0);
  assign irq_o       = evt_valid_o;
  assign evt_count_o = count;
  assign evt_id_o    = evt_valid_o ? mem[rd_ptr] : '0;
  assign pop         = evt_valid_o & evt_ready_i;
  assign push_ok     = (count != FULL_CNT) | pop;
  assign push        = grant_vld;

  // Source vector: presses first, then releases when enabled.
  always_comb begin
    logic [N_BTN-1:0] rise;
    rise = {N_BTN{armed}} & btn_i & ~btn_q & mask_i;
`ifdef BTN_RELEASE_EVT_EN
    src_edge = {{N_BTN{armed}} & ~btn_i & btn_q & mask_i, rise};
    src_en   = {mask_i, mask_i};
`else
    src_edge = rise;
    src_en   = mask_i;
`endif
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < N_SRC; k++) begin
      automatic int idx = (int'(rr_ptr) + k) % N_SRC;
      if (!grant_vld && push_ok && pending[idx]) begin
        grant_vld = 1'b1;
        grant_idx = SRC_W'(idx);
      end
    end
  end

  // Edge set wins over the grant clear; disabled sources drop their pending bit.
  always_comb begin
    grant_oh    = grant_vld ? (N_SRC'(1) << grant_idx) : '0;
    pending_nxt = ((pending & ~grant_oh) | src_edge) & src_en;
    lost        = |(src_edge & pending & ~grant_oh);
    rr_nxt      = rr_ptr;
    if (grant_vld)
      rr_nxt = (int'(grant_idx) == N_SRC - 1) ? '0 : grant_idx + SRC_W'(1);
  end

  always_comb begin
`ifdef BTN_RELEASE_EVT_EN
    if (int'(grant_idx) >= N_BTN)
      entry = {1'b1, ID_W'(int'(grant_idx) - N_BTN)};
    else
      entry = {1'b0, ID_W'(grant_idx)};
`else
    entry = {1'b0, ID_W'(grant_idx)};
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q   <= '0;
      armed   <= 1'b0;
      pending <= '0;
      rr_ptr  <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_o   <= 1'b0;
    end else begin
      btn_q   <= btn_i;
      armed   <= 1'b1;
      pending <= pending_nxt;
      rr_ptr  <= rr_nxt;
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (lost)
        ovf_o <= 1'b1;
      else if (ovf_clr_i)
        ovf_o <= 1'b0;
    end
  end

  // Storage needs no reset: empty entries are never presented.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= entry;
  end

endmodule
